// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: widths, register count and ALU op codes
// used by the decoder, the operand stage and the ALU.
package cpu_pkg;

   localparam int DATA_W  = 32;
   localparam int OP_W    = 3;
   localparam int REG_CNT = 8;
   localparam int REG_AW  = $clog2(REG_CNT);

   localparam logic [OP_W-1:0] OP_PASS_A = 3'd0;
   localparam logic [OP_W-1:0] OP_ADD    = 3'd1;
   localparam logic [OP_W-1:0] OP_SUB    = 3'd2;
   localparam logic [OP_W-1:0] OP_AND    = 3'd3;
   localparam logic [OP_W-1:0] OP_OR     = 3'd4;
   localparam logic [OP_W-1:0] OP_XOR    = 3'd5;
   localparam logic [OP_W-1:0] OP_SLL    = 3'd6;
   localparam logic [OP_W-1:0] OP_SRL    = 3'd7;

endpackage

// File: rtl/cpu_regfile.sv
// Architectural register file: two async read ports, one sync write port.
// Register 0 is hardwired to zero; writes to it are dropped.
module cpu_regfile
   import cpu_pkg::*;
#(
   parameter  int DATA_W  = cpu_pkg::DATA_W,
   parameter  int REG_CNT = cpu_pkg::REG_CNT,
   localparam int AW      = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     ra,
   input  logic [AW-1:0]     rb,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] regs [REG_CNT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
      end else if (we && wa != '0) begin
         regs[wa] <= wd;
      end
   end

   assign rd_a = (ra == '0) ? '0 : regs[ra];
   assign rd_b = (rb == '0) ? '0 : regs[rb];

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the ALU: regfile read, RAW scoreboard, output register.
// Define ALU_OPERAND_BYPASS_EN to forward same-cycle write-back into operands.
module alu_operand_stage
   import cpu_pkg::*;
#(
   parameter  int DATA_W  = cpu_pkg::DATA_W,
   parameter  int REG_CNT = cpu_pkg::REG_CNT,
   parameter  int OP_W    = cpu_pkg::OP_W,
   localparam int AW      = $clog2(REG_CNT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [AW-1:0]     in_ra,
   input  logic [AW-1:0]     in_rb,
   input  logic [AW-1:0]     in_rd,
   input  logic              in_use_imm,
   input  logic [DATA_W-1:0] in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] src_a,
   output logic [DATA_W-1:0] src_b,
   output logic [OP_W-1:0]   op,
   output logic [AW-1:0]     out_rd,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_rd,
   input  logic [DATA_W-1:0] wb_data
);

   logic [REG_CNT-1:0] busy, busy_eff, busy_nxt;
   logic [DATA_W-1:0]  rf_a, rf_b, opnd_a, opnd_b;
   logic               wb_live, hazard, accept;

   cpu_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .ra    (in_ra),
      .rb    (in_rb),
      .rd_a  (rf_a),
      .rd_b  (rf_b),
      .we    (wb_en),
      .wa    (wb_rd),
      .wd    (wb_data)
   );

   assign wb_live = wb_en && (wb_rd != '0);

   // With forwarding, a register being written back this cycle is already usable.
   always_comb begin
      busy_eff = busy;
`ifdef ALU_OPERAND_BYPASS_EN
      if (wb_live) busy_eff[wb_rd] = 1'b0;
`endif
   end

   assign hazard   = (busy_eff[in_ra] && in_ra != '0) ||
                     (!in_use_imm && busy_eff[in_rb] && in_rb != '0);
   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   always_comb begin
      opnd_a = rf_a;
      opnd_b = in_use_imm ? in_imm : rf_b;
`ifdef ALU_OPERAND_BYPASS_EN
      if (wb_live && wb_rd == in_ra) opnd_a = wb_data;
      if (wb_live && !in_use_imm && wb_rd == in_rb) opnd_b = wb_data;
`endif
   end

   // Set after clear: a new writer issued alongside an old write-back stays pending.
   always_comb begin
      busy_nxt = busy;
      if (wb_live) busy_nxt[wb_rd] = 1'b0;
      if (accept && in_rd != '0) busy_nxt[in_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         src_a     <= '0;
         src_b     <= '0;
         op        <= '0;
         out_rd    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         src_a     <= opnd_a;
         src_b     <= opnd_b;
         op        <= in_op;
         out_rd    <= in_rd;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed hazard/stall/reset
// scenarios with literal expectations, then randomized traffic vs a model.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = '0;
   logic [2:0]  in_ra = '0;
   logic [2:0]  in_rb = '0;
   logic [2:0]  in_rd = '0;
   logic        in_use_imm = 1'b0;
   logic [31:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [2:0]  op;
   logic [2:0]  out_rd;
   logic        wb_en = 1'b0;
   logic [2:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;

   int vectors = 0;
   int miscompares = 0;

   // behavioural model state
   logic [31:0] m_regs [8];
   logic        m_busy [8];
   logic        m_ov;
   logic [31:0] m_a, m_b;
   logic [2:0]  m_op, m_rd;
   logic        exp_ready;

   alu_operand_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
      .in_use_imm(in_use_imm), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .src_a(src_a), .src_b(src_b), .op(op), .out_rd(out_rd),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 8; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_ov = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
   endtask

   function automatic logic reg_busy(input logic [2:0] r);
      if (r == 0) return 1'b0;
`ifdef ALU_OPERAND_BYPASS_EN
      if (wb_en && wb_rd == r) return 1'b0;
`endif
      return m_busy[r];
   endfunction

   function automatic logic [31:0] reg_val(input logic [2:0] r);
      if (r == 0) return '0;
`ifdef ALU_OPERAND_BYPASS_EN
      if (wb_en && wb_rd == r) return wb_data;
`endif
      return m_regs[r];
   endfunction

   function automatic logic model_ready();
      logic hz;
      hz = reg_busy(in_ra) || (!in_use_imm && reg_busy(in_rb));
      return (!m_ov || out_ready) && !hz;
   endfunction

   task automatic model_update(input logic acc);
      if (acc) begin
         m_a  = reg_val(in_ra);
         m_b  = in_use_imm ? in_imm : reg_val(in_rb);
         m_op = in_op;
         m_rd = in_rd;
         m_ov = 1'b1;
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      if (wb_en && wb_rd != 0) begin
         m_busy[wb_rd] = 1'b0;
         m_regs[wb_rd] = wb_data;
      end
      if (acc && in_rd != 0) m_busy[in_rd] = 1'b1;
   endtask

   // one cycle: compare everything against the model, then advance it
   task automatic step();
      logic acc;
      @(negedge clk);
      exp_ready = model_ready();
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      chk("src_a", src_a, m_a);
      chk("src_b", src_b, m_b);
      chk("op", {29'b0, op}, {29'b0, m_op});
      chk("out_rd", {29'b0, out_rd}, {29'b0, m_rd});
      acc = in_valid && exp_ready;
      @(posedge clk);
      model_update(acc);
      #1;
   endtask

   initial begin
      m_reset();
      #12 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: idle after reset, r0 write ignored
      step();
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_src_a", src_a, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      wb_en = 1; wb_rd = 0; wb_data = 32'hDEAD; step();
      wb_en = 0; in_valid = 1; in_ra = 0; in_rb = 0; in_rd = 0; in_op = 0; step();
      in_valid = 0;
      chk("r0_valid", {31'b0, out_valid}, 32'd1);
      chk("r0_src_a", src_a, 32'd0);

      // 2: basic register read
      wb_en = 1; wb_rd = 3; wb_data = 5; step();
      wb_rd = 4; wb_data = 7; step();
      wb_en = 0; in_valid = 1; in_op = 1; in_ra = 3; in_rb = 4; in_rd = 5; step();
      chk("t2_valid", {31'b0, out_valid}, 32'd1);
      chk("t2_src_a", src_a, 32'd5);
      chk("t2_src_b", src_b, 32'd7);
      chk("t2_op", {29'b0, op}, 32'd1);
      chk("t2_rd", {29'b0, out_rd}, 32'd5);

      // 3: RAW hazard on r5
      in_op = 4; in_ra = 5; in_rb = 0; in_rd = 6; #1;
      chk("t3_stall", {31'b0, in_ready}, 32'd0);
      wb_en = 1; wb_rd = 5; wb_data = 12; #1;
`ifdef ALU_OPERAND_BYPASS_EN
      chk("t3_bypass_ready", {31'b0, in_ready}, 32'd1);
      step();
      wb_en = 0;
`else
      chk("t3_wb_cycle_stall", {31'b0, in_ready}, 32'd0);
      step();
      wb_en = 0; #1;
      chk("t3_after_wb_ready", {31'b0, in_ready}, 32'd1);
      step();
`endif
      chk("t3_src_a", src_a, 32'd12);

      // 4: backpressure hold, then back-to-back issue
      out_ready = 0; in_op = 2; in_ra = 1; in_rb = 2; in_rd = 0; #1;
      chk("t4_blocked", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_hold_valid", {31'b0, out_valid}, 32'd1);
         chk("t4_hold_a", src_a, 32'd12);
         chk("t4_hold_op", {29'b0, op}, 32'd4);
         chk("t4_hold_rd", {29'b0, out_rd}, 32'd6);
      end
      out_ready = 1; step();
      chk("t4_b2b_op0", {29'b0, op}, 32'd2);
      in_op = 3; step();
      chk("t4_b2b_valid", {31'b0, out_valid}, 32'd1);
      chk("t4_b2b_op1", {29'b0, op}, 32'd3);

      // 5: immediate bypasses a busy rb (r6 still busy)
      in_ra = 0; in_rb = 6; in_use_imm = 1; in_imm = 32'hFFFF_FFFF; #1;
      chk("t5_ready", {31'b0, in_ready}, 32'd1);
      step();
      chk("t5_src_b", src_b, 32'hFFFF_FFFF);

      // 6: reset during stall clears scoreboard and file
      in_rd = 5; step();
      in_ra = 5; in_rd = 0; in_use_imm = 0; in_rb = 0; #1;
      chk("t6_stall", {31'b0, in_ready}, 32'd0);
      rst_n = 0; #1;
      chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("t6_rst_src_a", src_a, 32'd0);
      chk("t6_rst_ready", {31'b0, in_ready}, 32'd1);
      m_reset();
      rst_n = 1; #1;
      step();
      in_valid = 0;
      chk("t6_valid", {31'b0, out_valid}, 32'd1);
      chk("t6_src_a", src_a, 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         in_valid   = ($urandom_range(0, 3) != 0);
         in_op      = 3'($urandom);
         in_ra      = 3'($urandom);
         in_rb      = 3'($urandom);
         in_rd      = 3'($urandom);
         in_use_imm = ($urandom_range(0, 3) == 0);
         in_imm     = $urandom;
         out_ready  = ($urandom_range(0, 3) != 0);
         wb_en      = ($urandom_range(0, 9) < 6);
         wb_data    = $urandom;
         r = $urandom_range(0, 7);
         wb_rd = 3'(r);
         if ($urandom_range(0, 4) != 0) begin
            for (int k = 0; k < 8; k++) begin
               if (m_busy[(r + k) % 8]) begin
                  wb_rd = 3'((r + k) % 8);
                  break;
               end
            end
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the ALU in the 07 CPU datapath.
- Holds the 8x32 register file and reads two source operands (or one register plus an immediate).
- Registers src_a/src_b/op toward the ALU with a valid/ready handshake.
- Accepts ALU-result write-back and keeps a per-register busy scoreboard that stalls issue on read-after-write hazards.

Parameters:
- DATA_W, 32, operand/register width
- REG_CNT, 8, number of architectural registers (reg 0 hardwired to zero)
- OP_W, 3, ALU operation code width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction presented
- in_ready  out  1  stage accepts instruction this cycle
- in_op  in  OP_W  ALU op code, passed through unchanged
- in_ra  in  log2(REG_CNT)  source register A
- in_rb  in  log2(REG_CNT)  source register B
- in_rd  in  log2(REG_CNT)  destination register
- in_use_imm  in  1  1: src_b = in_imm, rb ignored
- in_imm  in  DATA_W  immediate operand
- out_valid  out  1  operands valid toward ALU
- out_ready  in  1  ALU stage accepts
- src_a  out  DATA_W  operand A
- src_b  out  DATA_W  operand B
- op  out  OP_W  registered op code
- out_rd  out  log2(REG_CNT)  destination tag travelling with the op
- wb_en  in  1  write-back strobe
- wb_rd  in  log2(REG_CNT)  write-back register
- wb_data  in  DATA_W  write-back value (ALU res)

Behaviour:
- Reset (async, rst_n=0):
  - all registers, src_a, src_b, op and out_rd are 0; out_valid=0; busy mask=0.
  - An instruction in flight is discarded; nothing is written.
- Register file:
  - Write on clk when wb_en=1 and wb_rd!=0. Writes to reg 0 are ignored; reads of reg 0 always return 0.
- Hazard detection:
  - hazard = (busy[in_ra] && in_ra!=0) || (!in_use_imm && busy[in_rb] && in_rb!=0).
  - A register being written back in the same cycle counts as not busy only when BYPASS_EN is defined.
- in_ready = (!out_valid || out_ready) && !hazard. It is combinational and depends on the in_* inputs only for the hazard term.
- Accept (in_valid && in_ready):
  - Next cycle: src_a, src_b, op and out_rd load, and out_valid=1.
  - Latency is 1 cycle from accept to out_valid.
- Hold: while out_valid && !out_ready, all outputs stay stable.
- Drain: out_ready=1 with no accept -> out_valid=0 next cycle; data outputs keep their last value.
- Throughput: 1 instruction/cycle when no hazard and out_ready is held high.
- Scoreboard:
  - Accept with in_rd!=0 sets busy[in_rd].
  - wb_en with wb_rd!=0 clears busy[wb_rd].
  - Same cycle, same register: set wins, because the newer writer is pending.
- Undefined op codes are passed through unchanged; decoding them is the ALU's job.
- No arithmetic in this block. Operands are raw DATA_W values; the immediate is not extended or truncated.

Optional Feature:
- Macro: ALU_OPERAND_BYPASS_EN.
- Defined:
  - A same-cycle write-back (wb_en, wb_rd==in_ra or in_rb, wb_rd!=0) forwards wb_data into the captured operand.
  - That register is treated as not busy for the hazard check, so there is no stall bubble.
- Undefined:
  - No forwarding. The register stays busy until the write-back cycle ends.
  - Issue resumes the following cycle, reading the written value from the file (one-cycle bubble).

Decomposition:
- Shared package cpu_pkg:
  - DATA_W, OP_W, REG_CNT, REG_AW constants.
  - ALU op code constants (OP_PASS_A=0, OP_ADD=1, ...) shared with the ALU and decoder.
- One sub-module, cpu_regfile:
  - 2 async read ports, 1 sync write port, reg-0-zero rule, async active-low reset.
- Scoreboard, hazard logic, bypass mux and output register stay in the top.

Test Plan:
1. Reset then idle -> out_valid=0, all outputs 0, in_ready=1; read of r0 after wb_en to r0 with 0xDEAD -> src_a=0.
2. wb r3=5, r4=7, then issue op=1, ra=3, rb=4, rd=5 -> next cycle out_valid=1, src_a=5, src_b=7, op=1, out_rd=5, busy[5]=1.
3. Issue writing r5, then an instruction reading r5 with no wb -> in_ready=0. With wb r5=12 that cycle:
   - bypass: accept, src_a=12.
   - no bypass: accept next cycle, src_a=12.
4. out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; out_ready=1 -> back-to-back issue at 1/cycle.
5. in_use_imm=1, imm=0xFFFF_FFFF, rb busy -> no stall, src_b=0xFFFF_FFFF.
6. rst_n low mid-stall with busy[5]=1 -> out_valid=0, busy cleared, next instruction reading r5 accepted and reads 0.
